// File: rtl/zap_predecode_fetch_buffer_pkg.sv
// ============================================================================
// zap_predecode_fetch_buffer_pkg : entry layout shared by the fetch skid buffer
// Revision : 1.0
// ============================================================================
`default_nettype none

package zap_predecode_fetch_buffer_pkg;

  localparam int ZAP_FBUF_INSTR_W   = 35;
  localparam int ZAP_FBUF_PC_W      = 32;
  localparam int ZAP_FBUF_ENTRY_W   = ZAP_FBUF_INSTR_W + ZAP_FBUF_PC_W + 2;

  localparam int ZAP_FBUF_INSTR_LSB = 0;
  localparam int ZAP_FBUF_PC_LSB    = ZAP_FBUF_INSTR_LSB + ZAP_FBUF_INSTR_W;
  localparam int ZAP_FBUF_IRQ_BIT   = ZAP_FBUF_PC_LSB + ZAP_FBUF_PC_W;
  localparam int ZAP_FBUF_FIQ_BIT   = ZAP_FBUF_IRQ_BIT + 1;

  // Packed MSB-first, so field positions match the offsets above.
  typedef struct packed {
    logic                        fiq;
    logic                        irq;
    logic [ZAP_FBUF_PC_W-1:0]    pc;
    logic [ZAP_FBUF_INSTR_W-1:0] instr;
  } zap_fbuf_entry_t;

endpackage

`default_nettype wire

// File: rtl/zap_predecode_fetch_buffer_fifo.sv
// ============================================================================
// zap_sync_fifo2 : generic 2-entry synchronous FIFO with flush, push, pop
// Revision : 1.0
// ============================================================================
`default_nettype none

module zap_sync_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q,  count_d;
  logic             w_push, w_pop, w_clr;

  assign w_clr  = rst_i | flush_i;
  assign w_push = push_i & (count_q != 2'd2);
  assign w_pop  = pop_i  & (count_q != 2'd0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (w_clr) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (w_pop)  rd_ptr_d = ~rd_ptr_q;
      if (w_push) wr_ptr_d = ~wr_ptr_q;
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    rd_ptr_q <= rd_ptr_d;
    wr_ptr_q <= wr_ptr_d;
    count_q  <= count_d;
    if (!w_clr && w_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/zap_predecode_fetch_buffer.sv
// ============================================================================
// zap_predecode_fetch_buffer : 2-entry fetch skid buffer with stall/clear decode
// Optional zero-latency bypass: ZAP_FETCH_BUFFER_BYPASS_EN.  Revision : 1.0
// ============================================================================
`default_nettype none

module zap_predecode_fetch_buffer
  import zap_predecode_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [34:0] i_instruction,
  input  logic        i_instruction_valid,
  input  logic [31:0] i_pc,
  input  logic        i_irq,
  input  logic        i_fiq,
  input  logic        i_clear_from_writeback,
  input  logic        i_clear_from_alu,
  input  logic        i_data_stall,
  input  logic        i_stall_from_shifter,
  input  logic        i_issue_stall,
  input  logic        i_stall_from_decode,
  output logic [34:0] o_instruction,
  output logic        o_instruction_valid,
  output logic [31:0] o_pc,
  output logic        o_irq,
  output logic        o_fiq,
  output logic        o_stall_to_fetch
);

  logic            w_adv, w_flush, w_normal, w_push, w_pop, w_bypass;
  logic [1:0]      w_count;
  zap_fbuf_entry_t w_wr_entry, w_head;

  assign w_adv = ~i_data_stall & ~i_stall_from_shifter & ~i_issue_stall & ~i_stall_from_decode;

  // Writeback clear beats the data stall; the data stall beats the ALU clear.
  assign w_flush  = i_reset | i_clear_from_writeback | (~i_data_stall & i_clear_from_alu);
  assign w_normal = ~w_flush & ~i_data_stall;

`ifdef ZAP_FETCH_BUFFER_BYPASS_EN
  assign w_bypass = (w_count == 2'd0) & ~i_reset;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop  = w_normal & w_adv & (w_count != 2'd0);
  assign w_push = w_normal & i_instruction_valid & (w_count != 2'(DEPTH)) & ~(w_bypass & w_adv);

  assign w_wr_entry = '{fiq: i_fiq, irq: i_irq, pc: i_pc, instr: i_instruction};

  zap_sync_fifo2 #(
    .WIDTH (ZAP_FBUF_ENTRY_W)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .flush_i (w_flush),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_wr_entry),
    .head_o  (w_head),
    .count_o (w_count)
  );

  always_comb begin
    o_instruction       = '0;
    o_pc                = '0;
    o_irq               = 1'b0;
    o_fiq               = 1'b0;
    o_instruction_valid = 1'b0;
    if (w_count != 2'd0) begin
      o_instruction       = w_head.instr;
      o_pc                = w_head.pc;
      o_irq               = w_head.irq;
      o_fiq               = w_head.fiq;
      o_instruction_valid = 1'b1;
    end else if (w_bypass) begin
      o_instruction       = i_instruction;
      o_pc                = i_pc;
      o_irq               = i_irq;
      o_fiq               = i_fiq;
      o_instruction_valid = i_instruction_valid;
    end
  end

  assign o_stall_to_fetch = (w_count == 2'(DEPTH));

endmodule

`default_nettype wire
